// File: rtl/print_arbiter.sv
// Round-robin arbiter sharing one ready/valid console port among NCORES PRINT-issuing cores.
// Requesting cores are stalled until their value has been handed to the console.
module print_arbiter #(
    parameter int NCORES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCORES-1:0]    print_valid,
    input  logic [NCORES*16-1:0] print_data,
    output logic [NCORES-1:0]    core_stall,
    output logic [15:0]          out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_core,
    output logic [15:0]          print_count
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam logic [NCORES-1:0] ONE_HOT_LSB = NCORES'(1);
    localparam logic [3:0]        LAST_RST    = 4'(NCORES - 1);

    state_e              state_q, state_d;
    logic [3:0]          last_q, last_d;
    logic [3:0]          out_core_q, out_core_d;
    logic [15:0]         out_data_q, out_data_d;
    logic [15:0]         print_count_q, print_count_d;

    logic                sel_found_s;
    logic [3:0]          sel_idx_s;
    logic [3:0]          cand_s;
    logic [NCORES-1:0]   pv_sh_s;
    logic [NCORES*16-1:0] data_sh_s;
    logic [15:0]         sel_data_s;
    logic                out_valid_s;
    logic                hs_s;
    logic [NCORES-1:0]   ack_s;

    // Core index k positions after base, wrapping modulo NCORES.
    function automatic logic [3:0] rr_idx(input logic [3:0] base, input int k);
        int sum;
        sum = (int'(base) + k) % NCORES;
        return sum[3:0];
    endfunction

    // State register: all flops, reset to IDLE with core 0 holding first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_q        <= LAST_RST;
            out_core_q    <= 4'd0;
            out_data_q    <= 16'h0000;
            print_count_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            out_core_q    <= out_core_d;
            out_data_q    <= out_data_d;
            print_count_q <= print_count_d;
        end
    end

    // Round-robin search: first requesting core strictly after the last one served.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = 4'd0;
        cand_s      = 4'd0;
        pv_sh_s     = '0;
        for (int k = 1; k <= NCORES; k++) begin
            cand_s  = rr_idx(last_q, k);
            pv_sh_s = print_valid >> cand_s;
            if (!sel_found_s && pv_sh_s[0]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = cand_s;
            end else begin
                sel_found_s = sel_found_s;
            end
        end
        data_sh_s  = print_data >> {sel_idx_s, 4'b0000};
        sel_data_s = data_sh_s[15:0];
    end

    // Next-state logic: latch the winner on IDLE->SEND, retire it on the handshake.
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        out_core_d    = out_core_q;
        out_data_d    = out_data_q;
        print_count_d = print_count_q;
        case (state_q)
            IDLE: begin
                if (sel_found_s) begin
                    state_d    = SEND;
                    out_data_d = sel_data_s;
                    out_core_d = sel_idx_s;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (out_ready) begin
                    state_d       = IDLE;
                    last_d        = out_core_q;
                    print_count_d = print_count_q + 16'd1;
                end else begin
                    state_d = SEND;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: the granted core is released only during its handshake cycle.
    always_comb begin
        out_valid_s = (state_q == SEND);
        hs_s        = out_valid_s & out_ready;
        if (hs_s) begin
            ack_s = ONE_HOT_LSB << out_core_q;
        end else begin
            ack_s = '0;
        end
        core_stall = print_valid & ~ack_s;
    end

    assign out_valid   = out_valid_s;
    assign out_data    = out_data_q;
    assign out_core    = out_core_q;
    assign print_count = print_count_q;

endmodule

// File: tb/tb_print_arbiter.sv
// Randomized and directed bench for print_arbiter: a spec-level cycle model feeds a scoreboard
// queue of expected transfers that a separate monitor checks against the console port.
module tb_print_arbiter;

    localparam int N = 4;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     pv;
    logic [N*16-1:0]  pdata;
    logic [N-1:0]     core_stall;
    logic [15:0]      out_data;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_core;
    logic [15:0]      print_count;

    print_arbiter #(.NCORES(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .print_valid (pv),
        .print_data  (pdata),
        .core_stall  (core_stall),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_core    (out_core),
        .print_count (print_count)
    );

    typedef struct {
        int          core;
        logic [15:0] data;
    } xfer_t;

    xfer_t       exp_q[$];
    int          grant_log[$];
    int          n_chk  = 0;
    int          n_pass = 0;

    // reference model state
    bit          m_busy;
    int          m_last;
    int          m_gnt;
    logic [15:0] m_cnt;
    bit          rel[N];
    bit          e_stall;
    bit          m_found;
    int          m_c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: arbitration rules applied once per cycle on the current inputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_last = N - 1;
            m_gnt  = 0;
            m_cnt  = 16'h0000;
            exp_q.delete();
            for (int i = 0; i < N; i++) rel[i] = 1'b0;
        end else begin
            chk("out_valid", 32'(out_valid), 32'(m_busy));
            chk("print_count", 32'(print_count), 32'(m_cnt));
            for (int i = 0; i < N; i++) begin
                e_stall = pv[i] && !(m_busy && out_ready && (m_gnt == i));
                chk("core_stall", 32'(core_stall[i]), 32'(e_stall));
                rel[i] = pv[i] && !e_stall;
            end
            if (m_busy) begin
                if (out_ready) begin
                    m_busy = 1'b0;
                    m_last = m_gnt;
                    m_cnt  = m_cnt + 16'd1;
                end
            end else begin
                m_found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    m_c = (m_last + k) % N;
                    if (!m_found && pv[m_c]) begin
                        m_found = 1'b1;
                        m_gnt   = m_c;
                        exp_q.push_back('{core: m_c, data: pdata[m_c*16 +: 16]});
                    end
                end
                m_busy = m_found;
            end
        end
    end

    // Monitor: whatever the console sees must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            chk("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("out_data", 32'(out_data), 32'(exp_q[0].data));
                chk("out_core", 32'(out_core), 32'(exp_q[0].core));
                if (out_ready) begin
                    grant_log.push_back(int'(out_core));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic idle_wait();
        pv        = '0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    int  hold;
    bit  saw_zero;
    int  rr_start;

    initial begin
        rst_n     = 1'b0;
        pv        = 4'b0101;
        pdata     = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h0000);
        chk("rst_out_core", 32'(out_core), 32'd0);
        chk("rst_print_count", 32'(print_count), 32'd0);
        chk("rst_stall_eq_valid", 32'(core_stall), 32'(4'b0101));
        pv = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single request
        pdata[15:0] = 16'h0041;
        pv[0]       = 1'b1;
        out_ready   = 1'b1;
        @(negedge clk);
        chk("single_stall_first", 32'(core_stall[0]), 32'd1);
        @(negedge clk);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'h0041);
        chk("single_released", 32'(core_stall[0]), 32'd0);
        @(posedge clk); #1;
        pv[0] = 1'b0;
        chk("single_count", 32'(print_count), 32'd1);
        idle_wait();

        // round-robin, all cores requesting continuously; last served core is 0
        rr_start = 0;
        grant_log.delete();
        for (int i = 0; i < N; i++) pdata[i*16 +: 16] = 16'(i);
        pv = '1;
        repeat (12) @(posedge clk);
        #1;
        pv = '0;
        chk("rr_log_len", 32'(grant_log.size() >= 5), 32'd1);
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            chk("rr_order", 32'(grant_log[k]), 32'((rr_start + 1 + k) % N));
        idle_wait();

        // backpressure on core 2, core 3 arrives while it waits
        pdata[2*16 +: 16] = 16'h1234;
        pv[2]     = 1'b1;
        out_ready = 1'b0;
        hold      = 0;
        @(negedge clk);
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            out_ready = (c >= 6);
            if (c == 2) begin
                pdata[3*16 +: 16] = 16'h5555;
                pv[3] = 1'b1;
            end
            if (c == 7) pv[2] = 1'b0;
            @(negedge clk);
            if (out_valid && out_data == 16'h1234 && out_core == 4'd2) hold++;
            if (c < 6) chk("bp_other_stalled", 32'(core_stall[3]), 32'(pv[3]));
        end
        chk("bp_hold_cycles", 32'(hold), 32'd6);
        idle_wait();

        // request withdrawn mid-SEND
        pdata[1*16 +: 16] = 16'habcd;
        pv[1]     = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        pv[1] = 1'b0;
        rr_start = int'(m_cnt);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("withdraw_count", 32'(print_count), 32'(16'(rr_start + 1)));
        idle_wait();

        // reset during SEND
        out_ready         = 1'b0;
        pdata[2*16 +: 16] = 16'h7777;
        pv[2]             = 1'b1;
        @(posedge clk); #1;
        pdata[15:0] = 16'h0a0a;
        pv[0]       = 1'b1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_stall", 32'(core_stall), 32'(pv));
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        chk("rst_mid_count", 32'(print_count), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_prio_valid", 32'(out_valid), 32'd1);
        chk("rst_prio_core", 32'(out_core), 32'd0);
        @(posedge clk); #1;
        idle_wait();

        // counter wrap
        force dut.print_count_q = 16'hfffe;
        m_cnt = 16'hfffe;
        #1;
        release dut.print_count_q;
        pdata[1*16 +: 16] = 16'h00ff;
        pv[1]    = 1'b1;
        saw_zero = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (print_count == 16'h0000) saw_zero = 1'b1;
            @(posedge clk); #1;
        end
        pv = '0;
        chk("wrap_saw_zero", 32'(saw_zero), 32'd1);
        chk("wrap_count", 32'(print_count), 32'h0001);
        idle_wait();

        // randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (!pv[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        pv[i] = 1'b1;
                        pdata[i*16 +: 16] = 16'($urandom);
                    end
                end else if (rel[i]) begin
                    if ($urandom_range(0, 1) == 1) pdata[i*16 +: 16] = 16'($urandom);
                    else pv[i] = 1'b0;
                end else if ($urandom_range(0, 29) == 0) begin
                    pv[i] = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
        end
        pv        = '0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
